// File: rtl/command_receiver.sv
// Receive-side command parser: checks preamble/SFD, destination, type and CRC-32, then stages
// payload bytes and commits them on a good frame. Define RX_BROADCAST_EN to also accept ff:ff:ff:ff:ff:ff.
module command_receiver #(
    parameter logic [15:0] ETHERTYPE = 16'h88B6,
    parameter int          CMD_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic [1:0]  rx_ctl,
    input  logic [47:0] mac_addr,
    output logic [5:0]  cmd_addr,
    output logic [7:0]  cmd_data,
    output logic        cmd_wen,
    output logic        cmd_commit,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count
);

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [6:0]  WR_LIMIT = 7'(CMD_BYTES);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, DEST, SRC, TYPE, PAYLOAD, DROP, CHECK
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic        dest_hit;
    logic [31:0] crc;
    logic [2:0]  fill;
    logic [6:0]  wr_cnt;
    logic [7:0]  dl [4];
    logic [7:0]  type_hi;

    logic        byte_vld;
    logic        rx_err;
    logic        rx_idle;
    logic [47:0] mac_sh;
    logic        dest_hit_nx;
    logic        dest_any_nx;
    logic        fcs_ok;
`ifdef RX_BROADCAST_EN
    logic        bcast_hit;
    logic        bcast_hit_nx;
`endif

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        byte_vld    = (rx_ctl == 2'b11);
        rx_err      = (rx_ctl == 2'b01) || (rx_ctl == 2'b10);
        rx_idle     = (rx_ctl == 2'b00);
        mac_sh      = mac_addr << {idx, 3'b000};
        dest_hit_nx = dest_hit && (rx_data == mac_sh[47:40]);
`ifdef RX_BROADCAST_EN
        bcast_hit_nx = bcast_hit && (rx_data == 8'hFF);
        dest_any_nx  = dest_hit_nx || bcast_hit_nx;
`else
        dest_any_nx  = dest_hit_nx;
`endif
        // The four bytes still in the delay line are the received FCS.
        fcs_ok = (~crc == {dl[0], dl[1], dl[2], dl[3]});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= 4'd0;
            dest_hit    <= 1'b0;
`ifdef RX_BROADCAST_EN
            bcast_hit   <= 1'b0;
`endif
            crc         <= CRC_INIT;
            fill        <= 3'd0;
            wr_cnt      <= 7'd0;
            cmd_addr    <= 6'd0;
            cmd_data    <= 8'd0;
            cmd_wen     <= 1'b0;
            cmd_commit  <= 1'b0;
            frame_count <= 16'd0;
            drop_count  <= 16'd0;
        end else begin
            cmd_wen    <= 1'b0;
            cmd_commit <= 1'b0;
            if (rx_err && state != IDLE && state != DROP && state != CHECK) begin
                state      <= DROP;
                drop_count <= drop_count + 16'd1;
            end else begin
                case (state)
                    IDLE: begin
                        if (byte_vld) state <= (rx_data == 8'h55) ? PREAMBLE : DROP;
                    end
                    PREAMBLE: begin
                        if (rx_idle) begin
                            state <= IDLE;
                        end else if (byte_vld && rx_data == 8'hD5) begin
                            state     <= DEST;
                            idx       <= 4'd0;
                            dest_hit  <= 1'b1;
`ifdef RX_BROADCAST_EN
                            bcast_hit <= 1'b1;
`endif
                            crc       <= CRC_INIT;
                            fill      <= 3'd0;
                            wr_cnt    <= 7'd0;
                            cmd_addr  <= 6'd0;
                        end else if (byte_vld && rx_data != 8'h55) begin
                            state <= DROP;
                        end
                    end
                    DEST, SRC, TYPE: begin
                        if (rx_idle) begin
                            state      <= IDLE;
                            drop_count <= drop_count + 16'd1;
                        end else if (byte_vld) begin
                            crc <= crc_byte(crc, rx_data);
                            idx <= idx + 4'd1;
                            if (state == DEST) begin
                                dest_hit  <= dest_hit_nx;
`ifdef RX_BROADCAST_EN
                                bcast_hit <= bcast_hit_nx;
`endif
                                // Foreign destinations are dropped silently.
                                if (!dest_any_nx)      state <= DROP;
                                else if (idx == 4'd5) begin
                                    state <= SRC;
                                    idx   <= 4'd0;
                                end
                            end else if (state == SRC) begin
                                if (idx == 4'd5) begin
                                    state <= TYPE;
                                    idx   <= 4'd0;
                                end
                            end else if (idx == 4'd1) begin
                                state <= ({type_hi, rx_data} == ETHERTYPE) ? PAYLOAD : DROP;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (rx_idle) begin
                            state <= CHECK;
                        end else if (byte_vld) begin
                            if (fill == 3'd4) begin
                                crc <= crc_byte(crc, dl[0]);
                                if (wr_cnt < WR_LIMIT) begin
                                    cmd_wen  <= 1'b1;
                                    cmd_data <= dl[0];
                                    cmd_addr <= wr_cnt[5:0];
                                    wr_cnt   <= wr_cnt + 7'd1;
                                end
                            end else begin
                                fill <= fill + 3'd1;
                            end
                        end
                    end
                    CHECK: begin
                        if (fill == 3'd4 && wr_cnt != 7'd0 && fcs_ok) begin
                            cmd_commit  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            drop_count <= drop_count + 16'd1;
                        end
                        // A single idle gap means the next preamble may already be arriving.
                        state <= (byte_vld && rx_data == 8'h55) ? PREAMBLE : IDLE;
                    end
                    DROP: begin
                        if (rx_idle) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == PAYLOAD && byte_vld) begin
            dl[0] <= dl[1];
            dl[1] <= dl[2];
            dl[2] <= dl[3];
            dl[3] <= rx_data;
        end
        if (state == TYPE && byte_vld && idx == 4'd0) type_hi <= rx_data;
    end

endmodule

// File: tb/tb_command_receiver.sv
// Scoreboard bench for command_receiver: frames are built from the link rules, expected
// writes/commits are queued per frame and a monitor pops them as the DUT emits outputs.
module tb_command_receiver;

    localparam logic [47:0] MAC  = 48'h02_1A_2B_3C_4D_5E;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
`ifdef RX_BROADCAST_EN
    localparam bit BCAST_EN = 1'b1;
`else
    localparam bit BCAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [1:0]  rx_ctl = 2'b00;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        cmd_wen;
    logic        cmd_commit;
    logic [15:0] frame_count;
    logic [15:0] drop_count;

    int          checks = 0;
    int          errors = 0;
    logic [14:0] exp_q [$];
    logic [7:0]  pay [$];
    logic [7:0]  frm [$];
    int          pay_pos;
    logic [15:0] exp_frames = 16'd0;
    logic [15:0] exp_drops = 16'd0;
    logic [14:0] mon_act;

    command_receiver dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_ctl      (rx_ctl),
        .mac_addr    (MAC),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_wen     (cmd_wen),
        .cmd_commit  (cmd_commit),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write or commit the DUT shows must match the head of the queue.
    always @(negedge clk) begin
        if (reset_n && (cmd_wen || cmd_commit)) begin
            mon_act = cmd_commit ? 15'h4000 : {1'b0, cmd_addr, cmd_data};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected nothing", mon_act);
            end else begin
                chk(cmd_commit ? "commit" : "write", 32'(mon_act), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [31:0] crc_of(input int from, input int upto);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int k = from; k < upto; k++) begin
            c = c ^ {frm[k], 24'h0};
            for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return ~c;
    endfunction

    task automatic drive(input logic [1:0] c, input logic [7:0] d);
        @(negedge clk);
        rx_ctl  = c;
        rx_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'b00, 8'h00);
    endtask

    task automatic fill_seq(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'(i));
    endtask

    task automatic fill_rand(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    task automatic build_frame(input int pre, input logic [47:0] dest, input logic [15:0] etype,
                               input logic [31:0] fcs_xor);
        logic [31:0] fcs;
        frm.delete();
        repeat (pre) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 0; i < 6; i++) frm.push_back(dest[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        foreach (pay[i]) frm.push_back(pay[i]);
        fcs = crc_of(pre + 1, frm.size()) ^ fcs_xor;
        for (int i = 0; i < 4; i++) frm.push_back(fcs[31-8*i -: 8]);
        pay_pos = pre + 15;
    endtask

    // err_idx: position within the payload+FCS region replaced by an rx error, -1 for none.
    task automatic run_frame(input int pre, input logic [47:0] dest, input logic [15:0] etype,
                             input logic [31:0] fcs_xor, input int err_idx, input int gap);
        int n;
        int nw;
        bit accept;
        bit pass;
        build_frame(pre, dest, etype, fcs_xor);
        n = pay.size();
        accept = ((dest == MAC) || (BCAST_EN && dest == '1)) && (etype == 16'h88B6);
        if (accept) begin
            nw = (err_idx >= 0) ? err_idx - 4 : n;
            if (nw < 0) nw = 0;
            if (nw > 64) nw = 64;
            for (int j = 0; j < nw; j++) exp_q.push_back({1'b0, 6'(j), pay[j]});
            pass = (err_idx < 0) && (fcs_xor == 0) && (n >= 1);
            if (pass) begin
                exp_q.push_back(15'h4000);
                exp_frames++;
            end else begin
                exp_drops++;
            end
        end
        for (int i = 0; i < frm.size(); i++) begin
            if (err_idx >= 0 && i == pay_pos + err_idx) drive(2'b01, 8'h00);
            else                                        drive(2'b11, frm[i]);
        end
        idle(gap);
    endtask

    task automatic settle(input string name);
        idle(4);
        chk({name, "_frames"}, 32'(frame_count), 32'(exp_frames));
        chk({name, "_drops"}, 32'(drop_count), 32'(exp_drops));
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset with a busy line.
        reset_n = 1'b0;
        rx_ctl  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_data = (i % 2 == 0) ? 8'h55 : 8'hD5;
        end
        chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        chk("rst_cmd_data", 32'(cmd_data), 32'd0);
        chk("rst_cmd_wen", 32'(cmd_wen), 32'd0);
        chk("rst_cmd_commit", 32'(cmd_commit), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        rx_ctl = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        fill_seq(64);
        run_frame(7, MAC, 16'h88B6, 32'h0, -1, 3);
        settle("good");

        fill_seq(64);
        run_frame(7, MAC, 16'h88B6, 32'h1, -1, 3);
        settle("bad_fcs");

        fill_seq(64);
        run_frame(7, MAC, 16'h88B6, 32'h0, 10, 3);
        settle("rx_err");

        fill_seq(64);
        run_frame(7, MAC, 16'h88B6, 32'h0, -1, 3);
        settle("after_err");

        fill_rand(32);
        run_frame(7, '1, 16'h88B6, 32'h0, -1, 3);
        settle("broadcast");

        fill_rand(100);
        run_frame(7, MAC, 16'h88B6, 32'h0, -1, 3);
        settle("long");

        fill_seq(64);
        run_frame(7, MAC, 16'h88B5, 32'h0, -1, 3);
        settle("bad_type");

        // Frame truncated inside the source address.
        fill_seq(8);
        build_frame(7, MAC, 16'h88B6, 32'h0);
        exp_drops++;
        for (int i = 0; i < 17; i++) drive(2'b11, frm[i]);
        settle("truncated");

        fill_seq(0);
        run_frame(3, MAC, 16'h88B6, 32'h0, -1, 3);
        settle("fcs_only");

        fill_rand(20);
        run_frame(2, MAC, 16'h88B6, 32'h0, -1, 1);
        fill_rand(20);
        run_frame(2, MAC, 16'h88B6, 32'h0, -1, 3);
        settle("back_to_back");

        for (int r = 0; r < 16; r++) begin
            int sel;
            int n;
            int e;
            logic [47:0] d;
            logic [15:0] t;
            logic [31:0] x;
            sel = int'($urandom_range(0, 9));
            n   = int'($urandom_range(0, 90));
            fill_rand(n);
            if (sel < 7)      d = MAC;
            else if (sel < 8) d = '1;
            else              d = MAC ^ (48'h1 << $urandom_range(0, 47));
            t = ($urandom_range(0, 7) == 0) ? 16'h88B7 : 16'h88B6;
            x = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            e = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n + 3)) : -1;
            run_frame(int'($urandom_range(1, 7)), d, t, x, e, int'($urandom_range(1, 3)));
            settle("random");
        end

        // Reset in the middle of a payload: two bytes already written, then everything clears.
        fill_seq(20);
        build_frame(7, MAC, 16'h88B6, 32'h0);
        exp_q.push_back({1'b0, 6'd0, 8'h00});
        exp_q.push_back({1'b0, 6'd1, 8'h01});
        for (int i = 0; i < pay_pos + 6; i++) drive(2'b11, frm[i]);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        rx_ctl  = 2'b00;
        #1;
        chk("midrst_frame_count", 32'(frame_count), 32'd0);
        chk("midrst_drop_count", 32'(drop_count), 32'd0);
        chk("midrst_cmd_wen", 32'(cmd_wen), 32'd0);
        chk("midrst_cmd_addr", 32'(cmd_addr), 32'd0);
        chk("midrst_pending", 32'(exp_q.size()), 32'd0);
        exp_frames = 16'd0;
        exp_drops  = 16'd0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        fill_seq(64);
        run_frame(7, MAC, 16'h88B6, 32'h0, -1, 3);
        settle("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
